mem_responder_mc: RTL



---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_array_16.sv | 49 ++++
 rtl/mem_responder_mc.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the multi-cycle data-memory responder:
//   - DATA_W          : data word width (16)
//   - MEM_LATENCY_DEF : default request-to-data_valid latency in cycles
//   - mem_state_t     : responder FSM state encoding
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int DATA_W          = 16;
    localparam int MEM_LATENCY_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_array_16.sv
// -----------------------------------------------------------------------------
// mem_array_16
// Single-port 2**ADDR_W x 16 storage array: synchronous write, registered read.
// The read register only updates on i_re, so it holds the last read word and
// doubles as the responder's data_out register. Only that output register is
// reset; the storage contents are not.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-low reset of the read register
//   i_we     in   write enable
//   i_re     in   read enable (loads o_rdata)
//   i_addr   in   word index [ADDR_W-1:0]
//   i_wdata  in   write data [15:0]
//   o_rdata  out  registered read data [15:0]
// -----------------------------------------------------------------------------
module mem_array_16
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder_mc.sv
// -----------------------------------------------------------------------------
// mem_responder_mc
// Multi-cycle 16-bit data-memory responder. Accepts one request at a time,
// stalls the initiator while the request is in flight and completes it
// LATENCY cycles after acceptance (data_valid pulse in the DONE cycle).
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-low reset
//   enable      in   request strobe
//   wr          in   1 = write, 0 = read (sampled with enable)
//   addr        in   byte address; bits [ADDR_W:1] select the word
//   data_in     in   write data
//   stall       out  request in flight (combinational from state/enable)
//   data_valid  out  one-cycle completion pulse
//   data_out    out  read data, held until the next read completes
// -----------------------------------------------------------------------------
module mem_responder_mc
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = MEM_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] data_in,
    output logic              stall,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_out
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    mem_state_t        r_state, w_state_next;
    logic [3:0]        r_count, w_count_next;
    logic              r_wr;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_wdata;

    logic              w_accept;
    logic              w_enter_done;
    logic              w_wr;
    logic [ADDR_W-1:0] w_idx;
    logic [DATA_W-1:0] w_wdata;
    logic              w_we;
    logic              w_re;

    // Byte-select bit and bits above the word index are intentionally ignored.
    logic              w_unused_addr;
    assign w_unused_addr = &{1'b0, addr[0], addr[15:ADDR_W+1]};

    assign w_accept = (r_state == IDLE) && enable;

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_enter_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_count_next = CNT_INIT;
                    if (LATENCY == 1) begin
                        w_state_next = DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                // BUSY lasts LATENCY-1 cycles; leave when the count reaches 0.
                w_count_next = r_count - 4'd1;
                if (r_count <= 4'd1) begin
                    w_state_next = DONE;
                    w_enter_done = 1'b1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // With LATENCY=1 the array access happens on the accepting edge itself,
    // before the latches are loaded, so the live inputs are used then.
    assign w_idx   = w_accept ? addr[ADDR_W:1] : r_idx;
    assign w_wr    = w_accept ? wr             : r_wr;
    assign w_wdata = w_accept ? data_in        : r_wdata;

    // Gating with rst drops a pending transaction when reset lands on the
    // edge that would otherwise enter DONE.
    assign w_we = rst && w_enter_done && w_wr;
    assign w_re = rst && w_enter_done && !w_wr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_count <= 4'd0;
            r_wr    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_accept) begin
                r_wr    <= wr;
                r_idx   <= addr[ADDR_W:1];
                r_wdata <= data_in;
            end
        end
    end

    mem_array_16 #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_idx),
        .i_wdata (w_wdata),
        .o_rdata (data_out)
    );

    assign stall      = (r_state == BUSY) || w_accept;
    assign data_valid = (r_state == DONE);

endmodule
